// File: rtl/stm1_deframer_pkg.sv
// Shared constants, state encoding and payload beat type for the STM-1 receive deframer.
package stm1_deframer_pkg;

    localparam int unsigned STM1_LENGTH    = 270;
    localparam int unsigned STM1_WIDTH     = 9;
    localparam int unsigned SOH_COLS       = 9;
    localparam int unsigned VC4_COLS       = STM1_LENGTH - SOH_COLS;
    localparam int unsigned PRESYNC_FRAMES = 2;
    localparam int unsigned OOF_FRAMES     = 4;
    localparam int unsigned CHECK_COL      = 5;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned COL_W  = 9;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WIN_W  = 6 * DATA_W;

    localparam logic [DATA_W-1:0] A1_BYTE = 8'hF6;
    localparam logic [DATA_W-1:0] A2_BYTE = 8'h28;
    localparam logic [WIN_W-1:0]  FRAME_PATTERN =
        {A1_BYTE, A1_BYTE, A1_BYTE, A2_BYTE, A2_BYTE, A2_BYTE};

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } deframe_state_t;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] data;
    } vc4_beat_t;

endpackage

// File: rtl/stm1_frame_aligner.sv
// A1/A2 frame alignment: byte window, HUNT/PRESYNC/SYNC tracking and row/column position.
module stm1_frame_aligner
    import stm1_deframer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       sync_c,
    output logic [3:0] byte_row_c,
    output logic [8:0] byte_col_c,
    output logic       in_frame,
    output logic       lof
);

    deframe_state_t    state_q, state_d;
    // Previous five valid bytes; with the incoming byte they form the six-byte window.
    logic [WIN_W-DATA_W-1:0] hist_q, hist_d;
    logic [WIN_W-1:0]  window_c;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  confirm_q, confirm_d, confirm_inc_c;
    logic [CNT_W-1:0]  miss_q, miss_d, miss_inc_c;
    logic              lof_d, in_frame_d;
    logic              match_c, checkpoint_c;

    assign window_c      = {hist_q, rx_data};
    assign match_c       = (window_c == FRAME_PATTERN);
    assign sync_c        = (state_q == SYNC);
    assign confirm_inc_c = confirm_q + CNT_W'(1);
    assign miss_inc_c    = miss_q + CNT_W'(1);

    // Position of the incoming byte: one step past the last accepted byte.
    always_comb begin
        byte_row_c = row_q;
        byte_col_c = col_q + COL_W'(1);
        if (col_q == COL_W'(STM1_LENGTH - 1)) begin
            byte_col_c = '0;
            byte_row_c = (row_q == ROW_W'(STM1_WIDTH - 1)) ? '0 : row_q + ROW_W'(1);
        end
    end

    assign checkpoint_c = (byte_row_c == '0) && (byte_col_c == COL_W'(CHECK_COL));

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        row_d     = row_q;
        col_d     = col_q;
        confirm_d = confirm_q;
        miss_d    = miss_q;
        lof_d     = lof;
        if (rx_valid) begin
            hist_d = window_c[WIN_W-DATA_W-1:0];
            case (state_q)
                HUNT: begin
                    if (match_c) begin
                        state_d   = PRESYNC;
                        row_d     = '0;
                        col_d     = COL_W'(CHECK_COL);
                        confirm_d = '0;
                    end
                end
                PRESYNC: begin
                    row_d = byte_row_c;
                    col_d = byte_col_c;
                    if (checkpoint_c) begin
                        if (!match_c) begin
                            state_d = HUNT;
                        end else if (confirm_inc_c == CNT_W'(PRESYNC_FRAMES)) begin
                            state_d   = SYNC;
                            lof_d     = 1'b0;
                            miss_d    = '0;
                            confirm_d = '0;
                        end else begin
                            confirm_d = confirm_inc_c;
                        end
                    end
                end
                SYNC: begin
                    row_d = byte_row_c;
                    col_d = byte_col_c;
                    if (checkpoint_c) begin
                        if (match_c) begin
                            miss_d = '0;
                        end else if (miss_inc_c == CNT_W'(OOF_FRAMES)) begin
                            state_d = HUNT;
                            lof_d   = 1'b1;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_inc_c;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign in_frame_d = (state_d == SYNC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            hist_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            confirm_q <= '0;
            miss_q    <= '0;
            lof       <= 1'b1;
            in_frame  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            row_q     <= row_d;
            col_q     <= col_d;
            confirm_q <= confirm_d;
            miss_q    <= miss_d;
            lof       <= lof_d;
            in_frame  <= in_frame_d;
        end
    end

endmodule

// File: rtl/stm1_deframer.sv
// STM-1 receive deframer: aligns on A1/A2 and forwards the tagged VC4 area, dropping SOH columns.
module stm1_deframer
    import stm1_deframer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pay_data,
    output logic       pay_valid,
    output logic       pay_sof,
    output logic [3:0] pay_row,
    output logic [8:0] pay_col,
    output logic       in_frame,
    output logic       lof
);

    logic       sync_c;
    logic [3:0] byte_row_c;
    logic [8:0] byte_col_c;
    logic       fwd_c, sof_c;
    vc4_beat_t  beat_d, beat_q;

    stm1_frame_aligner u_aligner (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .sync_c     (sync_c),
        .byte_row_c (byte_row_c),
        .byte_col_c (byte_col_c),
        .in_frame   (in_frame),
        .lof        (lof)
    );

    // Forward only when aligned before this byte's own checkpoint update, past the SOH columns.
    assign fwd_c = rx_valid && sync_c && (byte_col_c >= COL_W'(SOH_COLS));
    assign sof_c = (byte_row_c == '0) && (byte_col_c == COL_W'(SOH_COLS));

    always_comb begin
        beat_d      = '0;
        beat_d.row  = byte_row_c;
        beat_d.col  = byte_col_c - COL_W'(SOH_COLS);
        beat_d.data = rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pay_valid <= 1'b0;
            pay_sof   <= 1'b0;
            beat_q    <= '0;
        end else begin
            pay_valid <= fwd_c;
            pay_sof   <= fwd_c && sof_c;
            if (fwd_c) begin
                beat_q <= beat_d;
            end
        end
    end

    assign pay_data = beat_q.data;
    assign pay_row  = beat_q.row;
    assign pay_col  = beat_q.col;

endmodule

// File: tb/tb_stm1_deframer.sv
// Directed bench for stm1_deframer: lock, gapped input, flywheel/OOF, false pattern, slip and reset.
module tb_stm1_deframer;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_sof;
    logic [3:0] pay_row;
    logic [8:0] pay_col;
    logic       in_frame;
    logic       lof;

    int checks, passes;
    int pv_cnt, sof_cnt, seq_err, gap_err, er, ec;
    bit chk_data;
    logic pre_in, ck_in, ck_lof, ck6_in, ck6_lof;

    stm1_deframer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pay_data  (pay_data),
        .pay_valid (pay_valid),
        .pay_sof   (pay_sof),
        .pay_row   (pay_row),
        .pay_col   (pay_col),
        .in_frame  (in_frame),
        .lof       (lof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload byte at VC4 row r, column c.
    function automatic logic [7:0] pl(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    // hdr: 0 = no framing bytes, 1 = good A1/A2, 2 = last A2 corrupted.
    function automatic logic [7:0] frame_byte(input int idx, input int hdr, input int fake_at);
        int r, c;
        r = idx / 270;
        c = idx % 270;
        if (fake_at >= 0 && idx >= fake_at && idx < fake_at + 6)
            return (idx - fake_at < 3) ? 8'hF6 : 8'h28;
        if (r == 0 && c < 6) begin
            if (hdr == 0) return 8'h00;
            if (hdr == 2 && c == 5) return 8'h00;
            return (c < 3) ? 8'hF6 : 8'h28;
        end
        if (c < 9) return 8'h00;
        return pl(r, c - 9);
    endfunction

    task automatic clear_mon();
        pv_cnt = 0; sof_cnt = 0; seq_err = 0; gap_err = 0; er = 0; ec = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic v);
        rx_data  = d;
        rx_valid = v;
        @(posedge clk);
        #1;
        if (pay_valid === 1'b1) begin
            pv_cnt++;
            if (pay_sof === 1'b1) sof_cnt++;
            if (!v) gap_err++;
            if (chk_data && (pay_row !== 4'(er) || pay_col !== 9'(ec) || pay_data !== pl(er, ec) ||
                             pay_sof !== ((er == 0 && ec == 0) ? 1'b1 : 1'b0)))
                seq_err++;
            ec++;
            if (ec == 261) begin
                ec = 0;
                er = (er == 8) ? 0 : er + 1;
            end
        end else if (pay_sof !== 1'b0) begin
            seq_err++;
        end
    endtask

    task automatic send_frame(input int hdr, input int fake_at, input int del_at, input int n_bytes, input bit gap);
        for (int i = 0; i < n_bytes; i++) begin
            if (i == del_at) continue;
            send_byte(frame_byte(i, hdr, fake_at), 1'b1);
            if (gap) send_byte(8'hF6, 1'b0);
            if (i == 4) pre_in = in_frame;
            if (i == 5) begin ck_in = in_frame; ck_lof = lof; end
            if (i == 6) begin ck6_in = in_frame; ck6_lof = lof; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b1; rx_data = 8'hF6;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pay_valid !== 1'b0) $display("FAIL reset_pay_valid got=%b exp=0", pay_valid); else passes++;
        checks++; if (pay_sof !== 1'b0) $display("FAIL reset_pay_sof got=%b exp=0", pay_sof); else passes++;
        checks++; if (pay_data !== 8'h00) $display("FAIL reset_pay_data got=%h exp=00", pay_data); else passes++;
        checks++; if (pay_row !== 4'd0 || pay_col !== 9'd0) $display("FAIL reset_pay_tag got=%0d/%0d exp=0/0", pay_row, pay_col); else passes++;
        checks++; if (in_frame !== 1'b0) $display("FAIL reset_in_frame got=%b exp=0", in_frame); else passes++;
        checks++; if (lof !== 1'b1) $display("FAIL reset_lof got=%b exp=1", lof); else passes++;
        rst_n = 1'b1; rx_valid = 1'b0;
    endtask

    task automatic test_clean_lock();
        clear_mon();
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b0 || ck_lof !== 1'b1) $display("FAIL clean_f0 got in_frame=%b lof=%b exp 0/1", ck_in, ck_lof); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b0) $display("FAIL clean_f1_in_frame got=%b exp=0", ck_in); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (pre_in !== 1'b0) $display("FAIL clean_f2_pre_ck got=%b exp=0", pre_in); else passes++;
        checks++; if (ck_in !== 1'b1 || ck_lof !== 1'b0) $display("FAIL clean_f2_ck got in_frame=%b lof=%b exp 1/0", ck_in, ck_lof); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (pv_cnt !== 4698) $display("FAIL clean_pay_count got=%0d exp=4698", pv_cnt); else passes++;
        checks++; if (sof_cnt !== 2) $display("FAIL clean_sof_count got=%0d exp=2", sof_cnt); else passes++;
        checks++; if (seq_err !== 0) $display("FAIL clean_sequence got=%0d errors exp=0", seq_err); else passes++;
    endtask

    task automatic test_gapped();
        clear_mon();
        send_frame(1, -1, -1, 2430, 1'b1);
        checks++; if (pv_cnt !== 2349) $display("FAIL gap_pay_count got=%0d exp=2349", pv_cnt); else passes++;
        checks++; if (sof_cnt !== 1) $display("FAIL gap_sof_count got=%0d exp=1", sof_cnt); else passes++;
        checks++; if (seq_err !== 0) $display("FAIL gap_sequence got=%0d errors exp=0", seq_err); else passes++;
        checks++; if (gap_err !== 0) $display("FAIL gap_idle_valid got=%0d exp=0", gap_err); else passes++;
        checks++; if (in_frame !== 1'b1) $display("FAIL gap_in_frame got=%b exp=1", in_frame); else passes++;
    endtask

    task automatic test_flywheel_oof();
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            send_frame(2, -1, -1, 2430, 1'b0);
            checks++; if (ck_in !== 1'b1 || ck_lof !== 1'b0) $display("FAIL fly_miss%0d got in_frame=%b lof=%b exp 1/0", k, ck_in, ck_lof); else passes++;
        end
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b1 || ck_lof !== 1'b0) $display("FAIL fly_good got in_frame=%b lof=%b exp 1/0", ck_in, ck_lof); else passes++;
        for (int k = 0; k < 3; k++) begin
            send_frame(2, -1, -1, 2430, 1'b0);
            checks++; if (ck_in !== 1'b1) $display("FAIL oof_miss%0d_in_frame got=%b exp=1", k, ck_in); else passes++;
        end
        send_frame(2, -1, -1, 2430, 1'b0);
        checks++; if (pre_in !== 1'b1) $display("FAIL oof_pre_ck got=%b exp=1", pre_in); else passes++;
        checks++; if (ck_in !== 1'b0 || ck_lof !== 1'b1) $display("FAIL oof_ck got in_frame=%b lof=%b exp 0/1", ck_in, ck_lof); else passes++;
        checks++; if (pv_cnt !== 16443) $display("FAIL fly_pay_count got=%0d exp=16443", pv_cnt); else passes++;
        checks++; if (sof_cnt !== 7) $display("FAIL fly_sof_count got=%0d exp=7", sof_cnt); else passes++;
        checks++; if (seq_err !== 0) $display("FAIL fly_sequence got=%0d errors exp=0", seq_err); else passes++;
    endtask

    task automatic test_false_pattern();
        clear_mon();
        send_frame(0, 645, -1, 2430, 1'b0);
        checks++; if (in_frame !== 1'b0 || lof !== 1'b1) $display("FAIL false_f0 got in_frame=%b lof=%b exp 0/1", in_frame, lof); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b0) $display("FAIL false_f1_in_frame got=%b exp=0", ck_in); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b0) $display("FAIL false_f2_in_frame got=%b exp=0", ck_in); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b0 || ck_lof !== 1'b1) $display("FAIL false_f3 got in_frame=%b lof=%b exp 0/1", ck_in, ck_lof); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b1 || ck_lof !== 1'b0) $display("FAIL false_f4 got in_frame=%b lof=%b exp 1/0", ck_in, ck_lof); else passes++;
        checks++; if (pv_cnt !== 2349 || seq_err !== 0) $display("FAIL false_payload got=%0d/%0d exp=2349/0", pv_cnt, seq_err); else passes++;
    endtask

    task automatic test_frame_shift();
        clear_mon();
        chk_data = 1'b0;
        send_frame(1, -1, 1000, 2430, 1'b0);
        for (int k = 1; k < 4; k++) begin
            send_frame(1, -1, -1, 2430, 1'b0);
            checks++; if (ck6_in !== 1'b1) $display("FAIL shift_f%0d_in_frame got=%b exp=1", k, ck6_in); else passes++;
        end
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b1) $display("FAIL shift_f4_pre_ck got=%b exp=1", ck_in); else passes++;
        checks++; if (ck6_in !== 1'b0 || ck6_lof !== 1'b1) $display("FAIL shift_oof got in_frame=%b lof=%b exp 0/1", ck6_in, ck6_lof); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b0) $display("FAIL shift_f5_in_frame got=%b exp=0", ck_in); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b0) $display("FAIL shift_f6_in_frame got=%b exp=0", ck_in); else passes++;
        clear_mon();
        chk_data = 1'b1;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b1 || ck_lof !== 1'b0) $display("FAIL shift_resync got in_frame=%b lof=%b exp 1/0", ck_in, ck_lof); else passes++;
        checks++; if (pv_cnt !== 2349 || seq_err !== 0) $display("FAIL shift_payload got=%0d/%0d exp=2349/0", pv_cnt, seq_err); else passes++;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_frame(1, -1, -1, 1180, 1'b0);
        checks++; if (pv_cnt !== 1135 || seq_err !== 0) $display("FAIL mid_pre_payload got=%0d/%0d exp=1135/0", pv_cnt, seq_err); else passes++;
        rst_n = 1'b0; rx_valid = 1'b1; rx_data = frame_byte(1180, 1, -1);
        @(posedge clk);
        #1;
        checks++; if (pay_valid !== 1'b0) $display("FAIL mid_pay_valid got=%b exp=0", pay_valid); else passes++;
        checks++; if (in_frame !== 1'b0 || lof !== 1'b1) $display("FAIL mid_state got in_frame=%b lof=%b exp 0/1", in_frame, lof); else passes++;
        rst_n = 1'b1;
        clear_mon();
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b0 || ck_lof !== 1'b1) $display("FAIL mid_f0 got in_frame=%b lof=%b exp 0/1", ck_in, ck_lof); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (ck_in !== 1'b0) $display("FAIL mid_f1_in_frame got=%b exp=0", ck_in); else passes++;
        send_frame(1, -1, -1, 2430, 1'b0);
        checks++; if (pre_in !== 1'b0 || ck_in !== 1'b1) $display("FAIL mid_f2 got pre=%b ck=%b exp 0/1", pre_in, ck_in); else passes++;
        checks++; if (pv_cnt !== 2349 || sof_cnt !== 1 || seq_err !== 0) $display("FAIL mid_payload got=%0d/%0d/%0d exp=2349/1/0", pv_cnt, sof_cnt, seq_err); else passes++;
    endtask

    initial begin
        checks = 0; passes = 0;
        chk_data = 1'b1;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        pre_in = 1'b0; ck_in = 1'b0; ck_lof = 1'b0; ck6_in = 1'b0; ck6_lof = 1'b0;
        clear_mon();
        test_reset();
        test_clean_lock();
        test_gapped();
        test_flywheel_oof();
        test_false_pattern();
        test_frame_shift();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
